// File: rtl/ex_trap_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ex_trap_arbiter
//  Purpose  : Latches rising edges of peripheral interrupt lines into pending
//             bits and arbitrates the enabled pending sources onto the core's
//             single external-trap valid/ready handshake, reporting the
//             granted source id.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1        system clock
//    rst_n      in   1        asynchronous active-low reset
//    src_irq    in   SRC_NUM  peripheral interrupt levels (sync to clk)
//    irq_en     in   SRC_NUM  per-source enable
//    pend_clr   in   SRC_NUM  software clear of pending bits (pulses)
//    pend       out  SRC_NUM  pending status
//    trap_valid out  1        to core_ex_trap_valid
//    trap_ready in   1        from core_ex_trap_ready
//    trap_id    out  ID_W     granted source index, stable while trap_valid
//  Build option
//    EX_TRAP_RR_EN  defined   : round-robin priority starting at rr_ptr
//                   undefined : fixed priority, lowest index wins
// ============================================================================
module ex_trap_arbiter #(
  parameter int SRC_NUM = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SRC_NUM-1:0] src_irq,
  input  logic [SRC_NUM-1:0] irq_en,
  input  logic [SRC_NUM-1:0] pend_clr,
  output logic [SRC_NUM-1:0] pend,
  output logic               trap_valid,
  input  logic               trap_ready,
  output logic [ID_W-1:0]    trap_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SRC_NUM-1:0] src_q;
  logic [SRC_NUM-1:0] pend_q, pend_d;
  logic               trap_valid_q, trap_valid_d;
  logic [ID_W-1:0]    trap_id_q, trap_id_d;

  logic [SRC_NUM-1:0] w_rise;
  logic [SRC_NUM-1:0] w_cand;
  logic [SRC_NUM-1:0] w_hs_clr;
  logic               w_hs;
  logic               w_any;
  logic [ID_W-1:0]    w_winner;

  assign w_rise = src_irq & ~src_q;
  assign w_cand = pend_q & irq_en;
  assign w_any  = |w_cand;
  assign w_hs   = trap_valid_q & trap_ready;

  // A fresh edge outranks both software clear and the handshake clear.
  assign w_hs_clr = w_hs ? (SRC_NUM'(1) << trap_id_q) : '0;
  assign pend_d   = w_rise | (pend_q & ~pend_clr & ~w_hs_clr);

`ifdef EX_TRAP_RR_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // Scan starting at rr_ptr, wrapping modulo SRC_NUM; first hit wins.
  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    w_winner = '0;
    for (int k = 0; k < SRC_NUM; k++) begin
      idx = (int'(rr_ptr_q) + k) % SRC_NUM;
      if (!found && w_cand[idx]) begin
        w_winner = ID_W'(idx);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_hs) begin
      rr_ptr_d = (trap_id_q == ID_W'(SRC_NUM - 1)) ? '0 : trap_id_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    w_winner = '0;
    for (int i = SRC_NUM - 1; i >= 0; i--) begin
      if (w_cand[i]) w_winner = ID_W'(i);
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    trap_valid_d = trap_valid_q;
    trap_id_d    = trap_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          trap_id_d    = w_winner;
          trap_valid_d = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        // Mask or clear of the granted source does not retract the request.
        if (w_hs) begin
          trap_valid_d = 1'b0;
          state_d      = ST_GAP;
        end
      end
      ST_GAP: begin
        trap_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        trap_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      pend_q       <= '0;
      trap_valid_q <= 1'b0;
      trap_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_irq;
      pend_q       <= pend_d;
      trap_valid_q <= trap_valid_d;
      trap_id_q    <= trap_id_d;
    end
  end

  assign pend       = pend_q;
  assign trap_valid = trap_valid_q;
  assign trap_id    = trap_id_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_trap_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_trap_arbiter
//  Purpose  : Self-checking bench for ex_trap_arbiter (SRC_NUM=8, ID_W=3):
//             directed scenarios plus randomized traffic against a
//             cycle-level reference model of the pending/grant rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_trap_arbiter;

  localparam int SRC_NUM = 8;
  localparam int ID_W    = 3;

  logic               clk;
  logic               rst_n;
  logic [SRC_NUM-1:0] src_irq;
  logic [SRC_NUM-1:0] irq_en;
  logic [SRC_NUM-1:0] pend_clr;
  logic [SRC_NUM-1:0] pend;
  logic               trap_valid;
  logic               trap_ready;
  logic [ID_W-1:0]    trap_id;

  int checks;
  int failures;
  int cyc;

  ex_trap_arbiter #(.SRC_NUM(SRC_NUM), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_irq   (src_irq),
    .irq_en    (irq_en),
    .pend_clr  (pend_clr),
    .pend      (pend),
    .trap_valid(trap_valid),
    .trap_ready(trap_ready),
    .trap_id   (trap_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    src_irq    = '0;
    irq_en     = '0;
    pend_clr   = '0;
    trap_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Spec-level arbitration choice over a candidate set.
  function automatic logic [ID_W-1:0] pick(input logic [SRC_NUM-1:0] c, input int rr);
    logic [ID_W-1:0] r;
    logic            found;
    r     = '0;
    found = 1'b0;
`ifdef EX_TRAP_RR_EN
    for (int k = 0; k < SRC_NUM; k++) begin
      if (!found && c[(rr + k) % SRC_NUM]) begin
        r     = ID_W'((rr + k) % SRC_NUM);
        found = 1'b1;
      end
    end
`else
    for (int i = 0; i < SRC_NUM; i++) begin
      if (!found && c[i]) begin
        r     = ID_W'(i);
        found = 1'b1;
      end
    end
`endif
    return r;
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++;
    if (pend !== 8'h00) begin failures++; $display("FAIL reset_pend: got %h want 00", pend); end
    checks++;
    if (trap_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", trap_valid); end
    checks++;
    if (trap_id !== 3'd0) begin failures++; $display("FAIL reset_id: got %0d want 0", trap_id); end
  endtask

  task automatic test_single();
    irq_en = 8'hFF; trap_ready = 1'b1; src_irq = '0; pend_clr = '0;
    step(); step();
    src_irq = 8'h20;
    step();
    src_irq = 8'h00;
    checks++;
    if (pend !== 8'h20 || trap_valid !== 1'b0) begin
      failures++; $display("FAIL single_pend: pend=%h valid=%b want pend=20 valid=0", pend, trap_valid);
    end
    step();
    checks++;
    if (trap_valid !== 1'b1 || trap_id !== 3'd5) begin
      failures++; $display("FAIL single_grant: valid=%b id=%0d want valid=1 id=5", trap_valid, trap_id);
    end
    step();
    checks++;
    if (trap_valid !== 1'b0 || pend !== 8'h00) begin
      failures++; $display("FAIL single_done: valid=%b pend=%h want valid=0 pend=00", trap_valid, pend);
    end
  endtask

  task automatic test_stall();
    trap_ready = 1'b0; irq_en = 8'hFF;
    src_irq = 8'h04;
    step();
    src_irq = 8'h00;
    step();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (trap_valid !== 1'b1 || trap_id !== 3'd2) begin
        failures++; $display("FAIL stall_hold[%0d]: valid=%b id=%0d want valid=1 id=2", i, trap_valid, trap_id);
      end
      src_irq = (i == 5) ? 8'h01 : 8'h00;
      step();
    end
    src_irq = 8'h00;
    trap_ready = 1'b1;
    step();
    checks++;
    if (trap_valid !== 1'b0 || pend !== 8'h01) begin
      failures++; $display("FAIL stall_done: valid=%b pend=%h want valid=0 pend=01", trap_valid, pend);
    end
    step();
    checks++;
    if (trap_valid !== 1'b0) begin failures++; $display("FAIL stall_gap: valid=%b want 0", trap_valid); end
    step();
    checks++;
    if (trap_valid !== 1'b1 || trap_id !== 3'd0) begin
      failures++; $display("FAIL stall_next: valid=%b id=%0d want valid=1 id=0", trap_valid, trap_id);
    end
    step();
    step();
  endtask

`ifndef EX_TRAP_RR_EN
  task automatic test_fixed_prio();
    logic [ID_W-1:0] exp_ids [3];
    int              last_cyc;
    int              n;
    exp_ids  = '{3'd1, 3'd3, 3'd6};
    last_cyc = 0;
    trap_ready = 1'b1; irq_en = 8'hFF;
    src_irq = 8'h4A;
    step();
    src_irq = 8'h00;
    checks++;
    if (pend !== 8'h4A) begin failures++; $display("FAIL prio_pend: got %h want 4a", pend); end
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (trap_valid !== 1'b1 && n < 8) begin step(); n++; end
      checks++;
      if (trap_valid !== 1'b1 || trap_id !== exp_ids[g]) begin
        failures++; $display("FAIL prio_grant[%0d]: valid=%b id=%0d want valid=1 id=%0d", g, trap_valid, trap_id, exp_ids[g]);
      end
      if (g > 0) begin
        checks++;
        if (cyc - last_cyc !== 3) begin
          failures++; $display("FAIL prio_spacing[%0d]: got %0d want 3", g, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      step();
    end
    checks++;
    if (pend !== 8'h00) begin failures++; $display("FAIL prio_end_pend: got %h want 00", pend); end
  endtask
`else
  task automatic test_rr();
    int prev;
    int n;
    int id;
    prev = -1;
    trap_ready = 1'b1; irq_en = 8'hFF;
    src_irq = 8'h0A;
    step();
    src_irq = 8'h00;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (trap_valid !== 1'b1 && n < 8) begin step(); n++; end
      id = int'(trap_id);
      checks++;
      if (trap_valid !== 1'b1 || (id != 1 && id != 3) || id == prev) begin
        failures++; $display("FAIL rr_grant[%0d]: valid=%b id=%0d prev=%0d want alternating 1/3", g, trap_valid, id, prev);
      end
      prev = id;
      step();
      src_irq = 8'h00;
      src_irq[id] = 1'b1;
      step();
      src_irq = 8'h00;
    end
    repeat (8) step();
  endtask
`endif

  task automatic test_mask_clear();
    irq_en = 8'h00; trap_ready = 1'b1; pend_clr = '0;
    src_irq = 8'h10;
    step();
    src_irq = 8'h00;
    step();
    checks++;
    if (pend !== 8'h10 || trap_valid !== 1'b0) begin
      failures++; $display("FAIL mask_pend: pend=%h valid=%b want pend=10 valid=0", pend, trap_valid);
    end
    repeat (3) step();
    checks++;
    if (trap_valid !== 1'b0) begin failures++; $display("FAIL mask_hold: valid=%b want 0", trap_valid); end
    irq_en = 8'h10;
    step();
    checks++;
    if (trap_valid !== 1'b1 || trap_id !== 3'd4) begin
      failures++; $display("FAIL mask_grant: valid=%b id=%0d want valid=1 id=4", trap_valid, trap_id);
    end
    step();
    checks++;
    if (pend !== 8'h00 || trap_valid !== 1'b0) begin
      failures++; $display("FAIL mask_done: pend=%h valid=%b want pend=00 valid=0", pend, trap_valid);
    end
    irq_en = 8'h00;
    src_irq = 8'h10;
    step();
    src_irq = 8'h00;
    step();
    src_irq = 8'h10; pend_clr = 8'h10;
    step();
    src_irq = 8'h00; pend_clr = 8'h00;
    checks++;
    if (pend[4] !== 1'b1) begin failures++; $display("FAIL clr_race: pend4=%b want 1", pend[4]); end
    pend_clr = 8'h10;
    step();
    pend_clr = 8'h00;
    checks++;
    if (pend !== 8'h00) begin failures++; $display("FAIL clr_plain: pend=%h want 00", pend); end
    irq_en = 8'hFF;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    irq_en = 8'hFF; trap_ready = 1'b0;
    src_irq = 8'h80;
    step();
    src_irq = 8'h00;
    step();
    checks++;
    if (trap_valid !== 1'b1 || trap_id !== 3'd7) begin
      failures++; $display("FAIL rstmid_pre: valid=%b id=%0d want valid=1 id=7", trap_valid, trap_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (trap_valid !== 1'b0 || pend !== 8'h00 || trap_id !== 3'd0) begin
      failures++; $display("FAIL rstmid_async: valid=%b pend=%h id=%0d want 0/00/0", trap_valid, pend, trap_id);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (trap_valid !== 1'b0 || pend !== 8'h00) begin
      failures++; $display("FAIL rstmid_after: valid=%b pend=%h want 0/00", trap_valid, pend);
    end
  endtask

  task automatic test_random();
    logic [SRC_NUM-1:0] m_pend, m_srcq, rise, n_pend, cand;
    logic               m_valid, m_gap, hs;
    logic [ID_W-1:0]    m_id;
    int                 m_rr;
    apply_reset();
    m_pend = '0; m_srcq = '0; m_valid = 1'b0; m_gap = 1'b0; m_id = '0; m_rr = 0;
    for (int c = 0; c < 400; c++) begin
      src_irq    = src_irq ^ (SRC_NUM'($urandom) & SRC_NUM'($urandom) & SRC_NUM'($urandom));
      irq_en     = SRC_NUM'($urandom) | SRC_NUM'($urandom);
      pend_clr   = SRC_NUM'($urandom) & SRC_NUM'($urandom) & SRC_NUM'($urandom) & SRC_NUM'($urandom);
      trap_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      rise = src_irq & ~m_srcq;
      hs   = m_valid && trap_ready;
      cand = m_pend & irq_en;
      for (int i = 0; i < SRC_NUM; i++) begin
        if (rise[i])                                  n_pend[i] = 1'b1;
        else if (pend_clr[i] || (hs && m_id == ID_W'(i))) n_pend[i] = 1'b0;
        else                                          n_pend[i] = m_pend[i];
      end
      if (m_valid) begin
        if (hs) begin
          m_valid = 1'b0;
          m_gap   = 1'b1;
          m_rr    = (int'(m_id) + 1) % SRC_NUM;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (cand != 0) begin
        m_id    = pick(cand, m_rr);
        m_valid = 1'b1;
      end
      m_pend = n_pend;
      m_srcq = src_irq;
      #1;
      cyc++;
      checks++;
      if (pend !== m_pend) begin
        failures++; $display("FAIL rand_pend[%0d]: got %h want %h", c, pend, m_pend);
      end
      checks++;
      if (trap_valid !== m_valid) begin
        failures++; $display("FAIL rand_valid[%0d]: got %b want %b", c, trap_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (trap_id !== m_id) begin
          failures++; $display("FAIL rand_id[%0d]: got %0d want %0d", c, trap_id, m_id);
        end
      end
    end
    src_irq = '0; pend_clr = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    test_reset();
    test_single();
    test_stall();
`ifndef EX_TRAP_RR_EN
    test_fixed_prio();
`else
    test_rr();
`endif
    test_mask_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_trap_arbiter.md
Name: ex_trap_arbiter

Overview:
- Collects up to SRC_NUM peripheral interrupt lines and latches rising edges into pending bits.
- Arbitrates the enabled pending sources onto the core's single external-trap valid/ready handshake (core_ex_trap_valid / core_ex_trap_ready).
- Sits in sparrow_soc between the peripherals (uart0, spi0, timer, fpioa GPIO) and the core.
- Exposes the granted source id so the trap handler can identify the source without polling.

Parameters:
- SRC_NUM, 8, number of interrupt sources (2..32).
- ID_W, 3, width of trap_id; must satisfy 2**ID_W >= SRC_NUM.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- src_irq  in  SRC_NUM  peripheral interrupt levels, synchronous to clk
- irq_en  in  SRC_NUM  per-source enable, driven from a CSR/peripheral register
- pend_clr  in  SRC_NUM  software clear of pending bits, one-cycle pulses
- pend  out  SRC_NUM  pending status, readable by software
- trap_valid  out  1  to core_ex_trap_valid
- trap_ready  in  1  from core_ex_trap_ready
- trap_id  out  ID_W  index of the granted source, valid while trap_valid=1

Behaviour:
- Reset values: pend=0, trap_valid=0, trap_id=0, src_q=0, FSM=IDLE, rr_ptr=0.
- Because src_q resets to 0, a source already high when reset releases produces one pending edge.
- Edge detect: src_q <= src_irq every cycle. rise[i] = src_irq[i] & ~src_q[i].
- Pending update, per bit, in priority order:
  - set if rise[i];
  - else clear if pend_clr[i], or if the handshake completes with trap_id==i;
  - else hold.
  - A new edge always wins over a simultaneous clear.
- Candidates: cand = pend & irq_en.
- FSM IDLE:
  - If cand != 0: select a winner per the priority rule, register trap_id=winner, set trap_valid=1, go REQ.
  - Else stay in IDLE.
- FSM REQ:
  - trap_valid=1; trap_id is held stable and never changes while valid.
  - On trap_valid & trap_ready: clear pend[trap_id], set trap_valid=0, go GAP.
  - Deasserting irq_en or pulsing pend_clr for the granted source while in REQ does not retract valid; the request completes normally.
- FSM GAP: one cycle with trap_valid=0, then IDLE. This guarantees at least one idle cycle between grants.
- Latency:
  - src_irq rising at edge n: pend visible after edge n+1, trap_valid high after edge n+2.
  - If trap_ready is already high, the handshake completes at edge n+3.
  - Back-to-back grants occur at most every 3 cycles.
- Repeated edges on one source before service merge into a single pending bit; no counting.
- Default priority (macro off): fixed, lowest index wins.
- trap_ready while trap_valid=0 is ignored.
- Asynchronous reset mid-REQ: all state drops to reset values immediately and the in-flight request is lost.

Optional Feature:
- Macro: EX_TRAP_RR_EN.
- Defined:
  - Round-robin priority. Search starts at index rr_ptr and wraps modulo SRC_NUM; the first candidate found wins.
  - On each completed handshake, rr_ptr <= trap_id+1, wrapping to 0 past SRC_NUM-1.
  - rr_ptr resets to 0.
- Undefined: fixed lowest-index priority. rr_ptr and its logic are not present.

Test Plan:
- Single source: irq_en=8'hFF, trap_ready=1. Pulse src_irq[5] for one cycle at edge 10 → pend[5]=1 after edge 11; trap_valid=1 and trap_id=5 after edge 12; handshake completes at edge 13; pend=0 and trap_valid=0 after edge 13.
- Stall: trap_ready=0 for 20 cycles with src_irq[2] pending → trap_valid stays 1 and trap_id stays 2 for all 20 cycles. Raise trap_ready → completes in one cycle, followed by a one-cycle GAP.
- Fixed priority (macro off): edges on sources 6, 1 and 3 in the same cycle, trap_ready=1 → grants in order 1, 3, 6, each spaced 3 cycles apart; pend ends at 0.
- Round-robin (EX_TRAP_RR_EN): keep sources 1 and 3 re-edging after each grant → grants alternate 1, 3, 1, 3; source 1 never wins twice in a row.
- Mask and clear:
  - irq_en=8'h00 with an edge on src 4 → pend[4]=1, trap_valid stays 0.
  - Set irq_en[4]=1 → trap_valid high next cycle with trap_id=4.
  - In a separate run, a pend_clr[4] pulse in the same cycle as a new src 4 edge → pend[4] stays 1.
- Reset mid-request: assert rst_n=0 while in REQ with id=7 → trap_valid=0, pend=0 and trap_id=0 immediately, without waiting for a clock edge.
